// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers a valid/ready stream into one of two channels.
// Each channel has a one-entry holding register, so a stalled channel
// never blocks words bound for the other channel.
// Optional macro DEMUX_STAT_EN adds per-channel 16-bit handshake counters
// (cnt0_o, cnt1_o) that count output handshakes and wrap at 16'hFFFF.
module demux_1to2_buf #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [size-1:0] data_i,
   input  logic            select_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [size-1:0] data0_o,
   output logic            valid0_o,
   input  logic            ready0_i,
   output logic [size-1:0] data1_o,
   output logic            valid1_o,
   input  logic            ready1_i
`ifdef DEMUX_STAT_EN
   ,
   output logic [15:0]     cnt0_o,
   output logic [15:0]     cnt1_o
`endif
);

   logic [size-1:0] data0_q, data0_d;
   logic [size-1:0] data1_q, data1_d;
   logic            valid0_q, valid0_d;
   logic            valid1_q, valid1_d;
   logic            acc;
   logic            drain0;
   logic            drain1;

   // ready depends only on the targeted channel: it has room, or it empties this cycle
   always_comb begin
      ready_o = select_i ? (~valid1_q | ready1_i) : (~valid0_q | ready0_i);
      acc     = valid_i & ready_o;
      drain0  = valid0_q & ready0_i;
      drain1  = valid1_q & ready1_i;
   end

   // next state per channel: a refill wins over a drain so a full pipe has no bubble
   always_comb begin
      data0_d  = data0_q;
      valid0_d = valid0_q;
      data1_d  = data1_q;
      valid1_d = valid1_q;
      if (acc && !select_i) begin
         data0_d  = data_i;
         valid0_d = 1'b1;
      end else if (drain0) begin
         valid0_d = 1'b0;
      end
      if (acc && select_i) begin
         data1_d  = data_i;
         valid1_d = 1'b1;
      end else if (drain1) begin
         valid1_d = 1'b0;
      end
   end

   // holding registers; reset drops buffered words without a handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data0_q  <= '0;
         valid0_q <= 1'b0;
         data1_q  <= '0;
         valid1_q <= 1'b0;
      end else begin
         data0_q  <= data0_d;
         valid0_q <= valid0_d;
         data1_q  <= data1_d;
         valid1_q <= valid1_d;
      end
   end

   assign data0_o  = data0_q;
   assign valid0_o = valid0_q;
   assign data1_o  = data1_q;
   assign valid1_o = valid1_q;

`ifdef DEMUX_STAT_EN
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   // handshake counters, free-running with natural wrap
   always_comb begin
      cnt0_d = drain0 ? cnt0_q + 16'd1 : cnt0_q;
      cnt1_d = drain1 ? cnt1_q + 16'd1 : cnt1_q;
   end

   // counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0_o = cnt0_q;
   assign cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed bench for demux_1to2_buf. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge.
module tb_demux_1to2_buf;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic        select_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data0_o;
   logic        valid0_o;
   logic        ready0_i;
   logic [31:0] data1_o;
   logic        valid1_o;
   logic        ready1_i;
`ifdef DEMUX_STAT_EN
   logic [15:0] cnt0_o;
   logic [15:0] cnt1_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   demux_1to2_buf #(.size(32)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .select_i (select_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data0_o  (data0_o),
      .valid0_o (valid0_o),
      .ready0_i (ready0_i),
      .data1_o  (data1_o),
      .valid1_o (valid1_o),
      .ready1_i (ready1_i)
`ifdef DEMUX_STAT_EN
      ,
      .cnt0_o   (cnt0_o),
      .cnt1_o   (cnt1_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i    = 1'b1;
      data_i   = '0;
      select_i = 1'b0;
      valid_i  = 1'b0;
      ready0_i = 1'b1;
      ready1_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;

      // reset and idle
      mid();
      chk("rst_valid0", 32'(valid0_o), 32'd0);
      chk("rst_valid1", 32'(valid1_o), 32'd0);
      chk("rst_data0", data0_o, 32'd0);
      chk("rst_data1", data1_o, 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
`ifdef DEMUX_STAT_EN
      chk("rst_cnt0", 32'(cnt0_o), 32'd0);
      chk("rst_cnt1", 32'(cnt1_o), 32'd0);
`endif

      // basic routing
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA5A5_0001;
      mid();
      chk("route_ready0", 32'(ready_o), 32'd1);
      step();
      select_i = 1'b1; data_i = 32'h5A5A_0002;
      mid();
      chk("route_valid0", 32'(valid0_o), 32'd1);
      chk("route_data0", data0_o, 32'hA5A5_0001);
      chk("route_valid1_early", 32'(valid1_o), 32'd0);
      step();
      valid_i = 1'b0;
      mid();
      chk("route_valid0_off", 32'(valid0_o), 32'd0);
      chk("route_valid1", 32'(valid1_o), 32'd1);
      chk("route_data1", data1_o, 32'h5A5A_0002);
      step();
      mid();
      chk("route_valid1_off", 32'(valid1_o), 32'd0);
      chk("route_data0_hold", data0_o, 32'hA5A5_0001);
`ifdef DEMUX_STAT_EN
      chk("route_cnt0", 32'(cnt0_o), 32'd1);
      chk("route_cnt1", 32'(cnt1_o), 32'd1);
`endif

      // per-channel backpressure
      ready0_i = 1'b0;
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'h11;
      step();
      data_i = 32'h22;
      mid();
      chk("bp_valid0", 32'(valid0_o), 32'd1);
      chk("bp_data0", data0_o, 32'h11);
      chk("bp_ready_blocked", 32'(ready_o), 32'd0);
      step();
      mid();
      chk("bp_data0_stable", data0_o, 32'h11);
      chk("bp_valid0_stable", 32'(valid0_o), 32'd1);
      select_i = 1'b1; data_i = 32'h33;
      #1;
      chk("bp_ready_other", 32'(ready_o), 32'd1);
      step();
      valid_i = 1'b0;
      mid();
      chk("bp_valid1", 32'(valid1_o), 32'd1);
      chk("bp_data1", data1_o, 32'h33);
      chk("bp_data0_still", data0_o, 32'h11);
      step();
      ready0_i = 1'b1;
      step();
      mid();
      chk("bp_drained", 32'({valid0_o, valid1_o}), 32'd0);

      // pass-through refill
      for (int i = 0; i < 8; i++) begin
         valid_i = 1'b1; select_i = 1'b0; data_i = 32'h100 + 32'(i);
         mid();
         chk("pt_ready", 32'(ready_o), 32'd1);
         if (i > 0) begin
            chk("pt_valid0", 32'(valid0_o), 32'd1);
            chk("pt_data0", data0_o, 32'h100 + 32'(i - 1));
         end
         step();
      end
      valid_i = 1'b0;
      mid();
      chk("pt_last_valid", 32'(valid0_o), 32'd1);
      chk("pt_last_data", data0_o, 32'h107);
      step();
      mid();
      chk("pt_end", 32'(valid0_o), 32'd0);
`ifdef DEMUX_STAT_EN
      chk("pt_cnt0", 32'(cnt0_o), 32'd10);
      chk("pt_cnt1", 32'(cnt1_o), 32'd2);
`endif

      // reset mid-operation
      ready0_i = 1'b0; ready1_i = 1'b0;
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'hAA;
      step();
      select_i = 1'b1; data_i = 32'hBB;
      step();
      valid_i = 1'b0;
      mid();
      chk("mr_full", 32'({valid0_o, valid1_o}), 32'd3);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      mid();
      chk("mr_valids", 32'({valid0_o, valid1_o}), 32'd0);
      chk("mr_data0", data0_o, 32'd0);
      chk("mr_data1", data1_o, 32'd0);
`ifdef DEMUX_STAT_EN
      chk("mr_cnt0", 32'(cnt0_o), 32'd0);
      chk("mr_cnt1", 32'(cnt1_o), 32'd0);
`endif

      // simultaneous drains on both channels
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'hCC;
      step();
      select_i = 1'b1; data_i = 32'hDD;
      step();
      valid_i = 1'b0;
      mid();
      chk("sd_data0", data0_o, 32'hCC);
      chk("sd_data1", data1_o, 32'hDD);
      ready0_i = 1'b1; ready1_i = 1'b1;
      step();
      mid();
      chk("sd_valids", 32'({valid0_o, valid1_o}), 32'd0);
`ifdef DEMUX_STAT_EN
      chk("sd_cnt0", 32'(cnt0_o), 32'd1);
      chk("sd_cnt1", 32'(cnt1_o), 32'd1);

      // counter wrap on channel 1
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      valid_i = 1'b1; select_i = 1'b1; data_i = 32'h77;
      for (int i = 0; i < 65536; i++) step();
      valid_i = 1'b0;
      mid();
      chk("wrap_ffff", 32'(cnt1_o), 32'hFFFF);
      step();
      mid();
      chk("wrap_zero", 32'(cnt1_o), 32'd0);
      chk("wrap_cnt0", 32'(cnt0_o), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux_1to2_buf.md
# demux_1to2_buf

Registered 1-to-2 demultiplexer that steers one valid/ready input stream into one of two output channels by a per-word select bit. Each channel has a one-entry holding register, so a stalled channel never blocks traffic bound for the other channel. It is the distribution-side counterpart of the datapath 2-to-1 selector. It sits between a pipeline stage producing results and two consumer stages, for example the writeback path and a store/side path.

## Interface
- `size`, default 32, width of the data word.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `data_i` in `size`: input word.
- `select_i` in 1: destination of `data_i`; 0 routes to channel 0, 1 routes to channel 1. Qualified by `valid_i`.
- `valid_i` in 1: input word valid.
- `ready_o` out 1: block accepts the input word this cycle.
- `data0_o` out `size`: channel 0 word.
- `valid0_o` out 1: channel 0 word valid.
- `ready0_i` in 1: channel 0 consumer ready.
- `data1_o` out `size`: channel 1 word.
- `valid1_o` out 1: channel 1 word valid.
- `ready1_i` in 1: channel 1 consumer ready.
- `cnt0_o` out 16: count of channel 0 output handshakes. Present only with `DEMUX_STAT_EN`.
- `cnt1_o` out 16: count of channel 1 output handshakes. Present only with `DEMUX_STAT_EN`.

## Operation
- Each channel k has a holding register (`data_k`, `valid_k`). `datak_o` and `validk_o` are driven directly from these registers; there is no combinational path from any input to them.
- Input handshake: `acc = valid_i & ready_o`.
- Output handshake for channel k: `drain_k = validk_o & readyk_i`.
- `ready_o = select_i ? (~valid1_o | ready1_i) : (~valid0_o | ready0_i)`. This is combinational on `select_i`, `validk_o` and `readyk_i`, and independent of `valid_i`.
- Channel k next state, in priority order:
  - `rst_i`: `valid_k` ← 0 and `data_k` ← 0.
  - `acc` with `select_i == k`: `data_k` ← `data_i` and `valid_k` ← 1. This applies even when `drain_k` fires in the same cycle (pass-through refill).
  - `drain_k`: `valid_k` ← 0; `data_k` holds.
  - Otherwise: hold.
- An accepted word goes to exactly one channel. The unselected channel is untouched by `acc`.
- While `validk_o & ~readyk_i`, `datak_o` and `validk_o` stay stable.
- Ordering is preserved within a channel. No ordering guarantee exists between channels.
- `select_i` is ignored when `valid_i` is 0.

## Timing
- Reset values: `valid0_o`=0, `valid1_o`=0, `data0_o`=0, `data1_o`=0, `cnt0_o`=0, `cnt1_o`=0.
- `ready_o` follows its inputs combinationally. After reset it is 1 from the first cycle.
- Latency: a word accepted in cycle n appears on `datak_o`/`validk_o` in cycle n+1.
- Throughput: one word per cycle when the targeted consumer holds ready high.
- Channel k full with `readyk_i`=0 gives `ready_o`=0 for words selecting k. Words selecting the other channel are still accepted if that channel can take them.
- Simultaneous drain and refill on the same channel keeps `validk_o` at 1 with the new data next cycle, with no bubble.
- Simultaneous drains on both channels in one cycle are legal and independent.
- Reset mid-operation discards buffered words without producing an output handshake. Counters clear.

## Configuration
- `DEMUX_STAT_EN` defined:
  - `cnt0_o` and `cnt1_o` exist.
  - `cntk_o` increments by 1 on each `drain_k`.
  - Counters wrap from 16'hFFFF to 16'h0000.
  - Counters clear on `rst_i`.
- `DEMUX_STAT_EN` undefined: counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset and idle: assert `rst_i` for 2 cycles with `ready0_i`=`ready1_i`=1 -> both valids 0, both data 0, `ready_o`=1, counters 0.
- Basic routing, `size`=32: send 32'hA5A5_0001 with select 0, then 32'h5A5A_0002 with select 1, one per cycle, consumers ready -> `data0_o`=A5A5_0001 one cycle after acceptance, `data1_o`=5A5A_0002 the following cycle, each valid for exactly 1 cycle. With `DEMUX_STAT_EN`, `cnt0_o`=1 and `cnt1_o`=1.
- Per-channel backpressure: hold `ready0_i`=0, fill channel 0 with 32'h11, offer 32'h22 to select 0 -> `ready_o`=0, `data0_o` stays 32'h11. Offer 32'h33 to select 1 -> accepted and delivered on channel 1 next cycle.
- Pass-through refill: stream 8 words to channel 0 on consecutive cycles with `ready0_i`=1 -> `valid0_o` high for 8 consecutive cycles, data in order, `ready_o` never 0.
- Reset mid-operation: both channels full and stalled, assert `rst_i` for 1 cycle -> next cycle both valids 0, no handshake recorded, counters 0.
- Counter wrap (`DEMUX_STAT_EN`): 65536 channel 1 drains -> `cnt1_o` returns to 0, `cnt0_o` unaffected.
